ucc_chain_sequencer: RTL and testbench
======================================

Name: ucc_chain_sequencer

Overview:
- Command-side driver for a cascaded chain of WIDTH 1-bit universal counter cells (UCC1Bit).
- It accepts one command at a time over a valid/ready handshake.
- It then drives the chain's shared mode bus, carry-in, serial-in and parallel-in lines cycle by cycle for the commanded duration.
- It counts carry-outs from the chain, captures the chain state on request, and signals completion with a one-cycle done pulse.

Parameters:
WIDTH, 4, number of cells in the driven chain (width of pin/chain_q/cmd_data)
LEN_W, 8, width of the command length field and of the internal step counter
OVF_W, 8, width of the carry-out (overflow) counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command (high only in IDLE)
cmd_op  input  2  00 LOAD, 01 COUNT, 10 SHIFT, 11 READ
cmd_data  input  WIDTH  load value (LOAD) or serial shift pattern (SHIFT)
cmd_len  input  LEN_W  number of active cycles for COUNT/SHIFT
m  output  2  mode bus to all cells: 00 hold, 01 count, 10 shift, 11 parallel load
cin  output  1  carry-in to cell 0
fin  output  1  serial input to cell 0
pin  output  WIDTH  parallel-load data to cells
chain_cout  input  1  carry-out of the last cell
chain_q  input  WIDTH  current chain state
rd_data  output  WIDTH  chain_q captured by READ
ovf_cnt  output  OVF_W  chain_cout pulses seen during COUNT
busy  output  1  command in progress (state != IDLE)
done  output  1  one-cycle pulse, last cycle of each command

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - m=00, cin=0, fin=0, pin=0, rd_data=0, ovf_cnt=0, done=0, busy=0.
  - cmd_ready=1 once rst_n=1.
- Outputs are registered. Accept means cmd_valid & cmd_ready at an edge. Command fields are latched at that edge and drive outputs from the following cycle; cmd_data changes after accept have no effect.
- States: IDLE, LOAD, RUN, READ, DONE.
- IDLE: m=00, cin=0, fin=0, pin=0. On accept:
  - op 00 -> LOAD.
  - op 11 -> READ.
  - op 01/10 with cmd_len=0 -> DONE directly.
  - otherwise -> RUN, with step counter=cmd_len and the shift register loaded with cmd_data.
- LOAD: exactly 1 cycle with m=11 and pin=latched data; cin=0, fin=0. Then -> DONE.
- RUN, op COUNT:
  - m=01 and cin=1 for exactly cmd_len cycles.
  - Each RUN cycle with chain_cout=1 increments ovf_cnt by 1.
  - ovf_cnt saturates at 2^OVF_W-1 and is not cleared by new commands (only by reset or a LOAD accept).
- RUN, op SHIFT:
  - m=10 for exactly cmd_len cycles.
  - fin = latched cmd_data bit 0, then bit 1, and so on (LSB first).
  - After WIDTH bits, fin=0 for the remaining cycles.
  - cin=0.
- Step counter decrements each RUN cycle; leaves RUN to DONE when it reaches 1.
- READ: 1 cycle with m=00; rd_data <= chain_q at the end of that cycle. Then -> DONE.
- DONE: 1 cycle with m=00, cin=0, fin=0, pin=0, done=1, busy=1. Then -> IDLE.
- done is never asserted in two consecutive cycles.
- LOAD accept clears ovf_cnt.
- Total cycles from accept edge to done:
  - LOAD: 2.
  - READ: 2.
  - COUNT/SHIFT with len L>0: L+1.
  - L=0: 1.
- cmd_valid while busy is ignored; cmd_ready=0, so the command is held by the source.
- Reset asserted mid-command aborts immediately: no done pulse, all outputs to reset values.
- LEN_W counter covers cmd_len = 2^LEN_W-1 without wrap.

Test Plan:
- Reset with rst_n low mid-RUN (COUNT len=10, cycle 4) -> m=00, cin=0, busy=0, done=0 immediately, without a clock edge; no done pulse afterwards.
- LOAD cmd_data=4'b1010 -> next cycle m=11, pin=1010 for 1 cycle; DONE the next cycle with done=1; cmd_ready returns 1 the cycle after; ovf_cnt=0.
- COUNT len=5, chain_cout driven high on RUN cycles 2 and 4 -> m=01, cin=1 for exactly 5 cycles; ovf_cnt=2; done 6 cycles after accept.
- SHIFT cmd_data=4'b0110, len=6 -> m=10 for 6 cycles; fin sequence 0,1,1,0,0,0; cin=0 throughout.
- READ with chain_q=4'b1101 -> rd_data=1101 after the READ cycle; m=00 throughout; done 2 cycles after accept.
- COUNT len=0 -> done in the cycle after accept; m never 01. Then cmd_valid held high with a second command during busy -> not accepted until cmd_ready=1.

Source files
------------

// File: rtl/ucc_chain_sequencer.sv
// Command sequencer for a chain of 1-bit universal counter cells: takes one
// command at a time and drives mode/carry/serial/parallel lines for its duration.
module ucc_chain_sequencer #(
  parameter int WIDTH = 4,
  parameter int LEN_W = 8,
  parameter int OVF_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [LEN_W-1:0] cmd_len,
  output logic [1:0]       m,
  output logic             cin,
  output logic             fin,
  output logic [WIDTH-1:0] pin,
  input  logic             chain_cout,
  input  logic [WIDTH-1:0] chain_q,
  output logic [WIDTH-1:0] rd_data,
  output logic [OVF_W-1:0] ovf_cnt,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_COUNT = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b11;

  localparam logic [1:0] M_HOLD  = 2'b00;
  localparam logic [1:0] M_COUNT = 2'b01;
  localparam logic [1:0] M_SHIFT = 2'b10;
  localparam logic [1:0] M_LOAD  = 2'b11;

  typedef enum logic [2:0] {st_idle, st_load, st_run, st_read, st_done} state_t;

  state_t           state, state_nx;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] sr_q;
  logic [LEN_W-1:0] cnt_q;
  logic             accept;

  function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
    return (&v) ? v : v + OVF_W'(1);
  endfunction

  assign accept = cmd_valid & cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= st_idle;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      st_idle: begin
        if (accept) begin
          case (cmd_op)
            OP_LOAD: state_nx = st_load;
            OP_READ: state_nx = st_read;
            default: state_nx = (cmd_len == '0) ? st_done : st_run;
          endcase
        end
      end
      st_load: state_nx = st_done;
      st_read: state_nx = st_done;
      st_run:  if (cnt_q == LEN_W'(1)) state_nx = st_done;
      st_done: state_nx = st_idle;
      default: state_nx = st_idle;
    endcase
  end

  // Command fields are captured once at accept; later cmd_data changes are ignored
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= cmd_op;
      data_q <= cmd_data;
      sr_q   <= cmd_data;
    end else if (state == st_run) begin
      sr_q <= sr_q >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      ovf_cnt <= '0;
      rd_data <= '0;
    end else begin
      if (accept)                 cnt_q <= cmd_len;
      else if (state == st_run)   cnt_q <= cnt_q - LEN_W'(1);

      if (accept && cmd_op == OP_LOAD)
        ovf_cnt <= '0;
      else if (state == st_run && op_q == OP_COUNT && chain_cout)
        ovf_cnt <= sat_inc(ovf_cnt);

      if (state == st_read) rd_data <= chain_q;
    end
  end

  // All outputs decode registered state only, so reset clears them without a clock
  always_comb begin
    m         = M_HOLD;
    cin       = 1'b0;
    fin       = 1'b0;
    pin       = '0;
    done      = 1'b0;
    busy      = (state != st_idle);
    cmd_ready = (state == st_idle);
    case (state)
      st_load: begin
        m   = M_LOAD;
        pin = data_q;
      end
      st_run: begin
        if (op_q == OP_COUNT) begin
          m   = M_COUNT;
          cin = 1'b1;
        end else begin
          m   = M_SHIFT;
          fin = sr_q[0];
        end
      end
      st_done: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ucc_chain_sequencer.sv
// Directed bench for ucc_chain_sequencer: a per-cycle schedule model checked
// every cycle, plus literal expectations for each scenario.
module tb_ucc_chain_sequencer;

  localparam int W  = 4;
  localparam int LW = 8;
  localparam int OW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [W-1:0]  cmd_data = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [1:0]    m;
  logic          cin, fin;
  logic [W-1:0]  pin;
  logic          chain_cout = 1'b0;
  logic [W-1:0]  chain_q = '0;
  logic [W-1:0]  rd_data;
  logic [OW-1:0] ovf_cnt;
  logic          busy, done;

  ucc_chain_sequencer #(.WIDTH(W), .LEN_W(LW), .OVF_W(OW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_len(cmd_len),
    .m(m), .cin(cin), .fin(fin), .pin(pin),
    .chain_cout(chain_cout), .chain_q(chain_q),
    .rd_data(rd_data), .ovf_cnt(ovf_cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each accepted command expands into a list of expected cycles
  typedef struct packed {
    logic [1:0]   m;
    logic         cin;
    logic         fin;
    logic [W-1:0] pin;
    logic         done;
    logic         cnt;
    logic         rd;
  } exp_t;

  exp_t          sched[$];
  logic [OW-1:0] m_ovf = '0;
  logic [W-1:0]  m_rd = '0;

  always @(posedge clk or negedge rst_n) begin
    exp_t cur;
    exp_t e;
    if (!rst_n) begin
      sched.delete();
      m_ovf = '0;
      m_rd  = '0;
    end else if (sched.size() > 0) begin
      cur = sched.pop_front();
      if (cur.cnt && chain_cout && m_ovf != {OW{1'b1}}) m_ovf = m_ovf + 1'b1;
      if (cur.rd) m_rd = chain_q;
    end else if (cmd_valid) begin
      e = '0;
      case (cmd_op)
        2'b00: begin
          e.m = 2'b11; e.pin = cmd_data; sched.push_back(e);
          m_ovf = '0;
        end
        2'b11: begin
          e.rd = 1'b1; sched.push_back(e);
        end
        default: begin
          for (int i = 0; i < int'(cmd_len); i++) begin
            e = '0;
            if (cmd_op == 2'b01) begin
              e.m = 2'b01; e.cin = 1'b1; e.cnt = 1'b1;
            end else begin
              e.m = 2'b10; e.fin = (i < W) ? cmd_data[i] : 1'b0;
            end
            sched.push_back(e);
          end
        end
      endcase
      e = '0; e.done = 1'b1;
      sched.push_back(e);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    logic eb;
    e  = (sched.size() > 0) ? sched[0] : '0;
    eb = (sched.size() > 0);
    chk("m", 32'(m), 32'(e.m));
    chk("cin", 32'(cin), 32'(e.cin));
    chk("fin", 32'(fin), 32'(e.fin));
    chk("pin", 32'(pin), 32'(e.pin));
    chk("done", 32'(done), 32'(e.done));
    chk("busy", 32'(busy), 32'(eb));
    chk("cmd_ready", 32'(cmd_ready), 32'(!eb));
    chk("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
    chk("rd_data", 32'(rd_data), 32'(m_rd));
  end

  // Per-command observations collected by send()
  int          lat, n_m01, n_m10, n_cin, n_mnz;
  logic [7:0]  fin_seq;
  logic [1:0]  m_first;
  logic [W-1:0] pin_first;
  logic [31:0] cout_mask = '0;
  logic        cout_all = 1'b0;

  task automatic send(input logic [1:0] op, input logic [W-1:0] data, input int len);
    int w;
    w = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_len = LW'(len);
    while (!cmd_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) chk("accept_timeout", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_data  = ~data;
    lat = 0; n_m01 = 0; n_m10 = 0; n_cin = 0; n_mnz = 0; fin_seq = '0;
    m_first = m; pin_first = pin;
    for (int k = 1; k <= 400; k++) begin
      chain_cout = cout_all | ((k < 32) ? cout_mask[k] : 1'b0);
      if (m == 2'b01) n_m01++;
      if (m == 2'b10) begin
        if (n_m10 < 8) fin_seq[n_m10] = fin;
        n_m10++;
      end
      if (cin) n_cin++;
      if (m != 2'b00) n_mnz++;
      if (done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    chain_cout = 1'b0;
    if (lat == 0) chk("done_timeout", 32'(lat), 32'd1);
  endtask

  initial begin
    int n, ndone;
    repeat (3) @(negedge clk);
    chk("rst_m", 32'(m), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(ovf_cnt), 32'd0);
    chk("rst_rd", 32'(rd_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(cmd_ready), 32'd1);

    // Async reset in RUN cycle 4 of COUNT len=10
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_len = 8'd10;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("run_before_rst_m", 32'(m), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_m", 32'(m), 32'd0);
    chk("async_rst_cin", 32'(cin), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("no_done_after_abort", 32'(ndone), 32'd0);

    // LOAD 1010
    send(2'b00, 4'b1010, 0);
    chk("load_lat", 32'(lat), 32'd2);
    chk("load_m", 32'(m_first), 32'd3);
    chk("load_pin", 32'(pin_first), 32'hA);
    chk("load_ovf", 32'(ovf_cnt), 32'd0);
    @(negedge clk);
    chk("load_ready_back", 32'(cmd_ready), 32'd1);

    // COUNT len=5 with carry-outs on RUN cycles 2 and 4
    cout_mask = 32'b10100;
    send(2'b01, 4'b0000, 5);
    cout_mask = '0;
    chk("count_lat", 32'(lat), 32'd6);
    chk("count_m01_cycles", 32'(n_m01), 32'd5);
    chk("count_cin_cycles", 32'(n_cin), 32'd5);
    @(negedge clk);
    chk("count_ovf", 32'(ovf_cnt), 32'd2);

    // SHIFT 0110 len=6
    send(2'b10, 4'b0110, 6);
    chk("shift_lat", 32'(lat), 32'd7);
    chk("shift_m10_cycles", 32'(n_m10), 32'd6);
    chk("shift_fin_seq", 32'(fin_seq), 32'b000110);
    chk("shift_cin", 32'(n_cin), 32'd0);

    // READ with chain_q=1101
    chain_q = 4'b1101;
    send(2'b11, 4'b0000, 0);
    chk("read_lat", 32'(lat), 32'd2);
    chk("read_m_active", 32'(n_mnz), 32'd0);
    chk("read_data", 32'(rd_data), 32'hD);

    // COUNT len=0
    send(2'b01, 4'b0000, 0);
    chk("len0_lat", 32'(lat), 32'd1);
    chk("len0_m01", 32'(n_m01), 32'd0);

    // Second command held while busy
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_len = 8'd3;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    cmd_op = 2'b11; chain_q = 4'b0011;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("held_wait_cycles", 32'(n), 32'd4);
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 1;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("held_read_lat", 32'(n), 32'd2);
    chk("held_read_data", 32'(rd_data), 32'h3);

    // Max length with carry-out every cycle: saturation and no counter wrap
    cout_all = 1'b1;
    send(2'b01, 4'b0000, 255);
    chk("max_len_lat", 32'(lat), 32'd256);
    chk("max_len_m01", 32'(n_m01), 32'd255);
    send(2'b01, 4'b0000, 3);
    cout_all = 1'b0;
    @(negedge clk);
    chk("ovf_saturated", 32'(ovf_cnt), 32'd255);
    send(2'b00, 4'b0101, 0);
    @(negedge clk);
    chk("ovf_cleared_by_load", 32'(ovf_cnt), 32'd0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t expected=finish", $time);
    $fatal(1, "timeout");
  end

endmodule
